dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Arbitrates the single-port data memory between the core's load/store path (requester 0) and the stack push/pop unit (requester 1). It sequences each access through the memory: request capture, issue, read-latency wait and response. It replaces the direct wiring of the datapath to the data memory, so a push/pop can no longer collide with an `lw`/`sw` in the same cycle. Only one memory transaction is ever outstanding.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width.
- `RD_LAT`, 1, memory read latency in cycles; legal range 1..4.

Ports:
- `clk`, in, 1, single clock, rising edge.
- `rst`, in, 1, reset; asynchronous, active-low.
- `req`, in, 2, per-requester request, level.
- `we`, in, 2, per-requester write enable (1 = store/push, 0 = load/pop).
- `addr0`, `addr1`, in, ADDR_W, request addresses.
- `wdata0`, `wdata1`, in, DATA_W, write data.
- `gnt`, out, 2, one-cycle grant pulse; at most one bit set.
- `rvalid`, out, 2, one-cycle read-data-valid pulse.
- `rdata`, out, DATA_W, read data; valid while any `rvalid` bit is set.
- `mem_addr`, out, ADDR_W, memory address.
- `mem_wdata`, out, DATA_W, memory write data.
- `mem_read`, out, 1, memory read strobe.
- `mem_write`, out, 1, memory write strobe.
- `mem_rdata`, in, DATA_W, memory read data.
- `busy`, out, 1, high whenever the state is not IDLE.

## Operation
- FSM states are IDLE, ISSUE, WAIT and RESP.
- **IDLE:**
  - If any `req` bit is set, pick a winner.
  - Latch the winner's index, `we`, address and wdata into command registers.
  - Go to ISSUE.
- **ISSUE:**
  - Drive `mem_addr`/`mem_wdata` from the command registers.
  - Assert exactly one of `mem_read`/`mem_write`.
  - Pulse `gnt[winner]`.
  - A write goes to IDLE; a read goes to WAIT.
- **WAIT:** a down-counter loaded with RD_LAT-1 in ISSUE. When the count is 0, capture `mem_rdata` into `rdata` and go to RESP. With RD_LAT=1, WAIT lasts exactly one cycle.
- **RESP:**
  - Pulse `rvalid[winner]`.
  - Go to IDLE.
  - `rdata` holds its value until the next read capture.
- Requester rules:
  - Hold `req`, `we`, `addr` and `wdata` stable until `gnt` is seen.
  - `req` must drop in the cycle after `gnt`; the arbiter ignores `req` outside IDLE.
- Tie (both `req` set in IDLE): resolved per Configuration.
- Reset, including mid-transaction, drives:
  - state to IDLE, and the counter to 0;
  - `gnt`, `rvalid`, `mem_read`, `mem_write` and `busy` to 0;
  - `rdata`, `mem_addr` and `mem_wdata` to 0.
  
  An in-flight read is discarded and no `rvalid` is produced.
- Outside ISSUE, `mem_addr`/`mem_wdata` hold their last value and both strobes are 0.

## Timing
Cycle N is the cycle in which `req` is sampled high in IDLE.
- **Write:** ISSUE at N+1 (strobe and `gnt`), IDLE at N+2. Back-to-back writes are accepted every 2 cycles.
- **Read:**
  - ISSUE at N+1.
  - WAIT for cycles N+2 .. N+1+RD_LAT, with `mem_rdata` sampled at the end of N+1+RD_LAT.
  - `rvalid` at N+2+RD_LAT.
  - IDLE at N+3+RD_LAT.
- Read request-to-`rvalid` latency is RD_LAT+2 cycles.
- All outputs are registered. There is no combinational path from `req` to `gnt`, or from `mem_rdata` to `rdata`.

## Configuration
- Macro: `DMEM_ARB_RR_EN`.
- **Defined:** round-robin arbitration.
  - A 1-bit `last` register records the most recently granted requester.
  - On a tie, the requester not equal to `last` wins.
  - Reset value of `last` is 1, so requester 0 wins the first tie.
- **Undefined:** fixed priority; requester 0 always wins ties, and requester 1 can starve.
- Timing is identical in both modes.

## Structure
- Package `dmem_arb_pkg` contains:
  - the state enum typedef `arb_state_t` (IDLE, ISSUE, WAIT, RESP);
  - constants `REQ_CORE=0` and `REQ_STACK=1`;
  - constant `RD_LAT_MAX=4`.
- Sub-module `dmem_arb_pick` is combinational.
  - Inputs: `req[1:0]`, plus `last` when `DMEM_ARB_RR_EN` is defined.
  - Outputs: winner index and a valid flag.
  - The FSM and datapath registers stay in `dmem_arbiter`.

## Test plan
- **Single write:** `req=01`, `we=01`, `addr0=0x10`, `wdata0=0xDEADBEEF`.
  - Expect `mem_write=1`, `mem_addr=0x10`, `mem_wdata=0xDEADBEEF`, `gnt=01` at N+1.
  - Expect `busy=0` at N+2.
- **Single read with RD_LAT=2:** `req=10`, `we=00`, `addr1=0x7C`, memory returns `0x12345678`.
  - Expect `gnt=10` at N+1.
  - Expect `rvalid=10`, `rdata=0x12345678` at N+4; no other `rvalid` pulse.
- **Tie, `DMEM_ARB_RR_EN` defined:** `req=11` held continuously (two writes).
  - Expect grant order 01, 10, 01.
- **Tie, `DMEM_ARB_RR_EN` undefined:** the same stimulus gives grant order 01, 01, 01.
- **Reset mid-read:** assert `rst=0` during WAIT.
  - Expect all outputs 0 immediately, with no `rvalid` afterwards.
  - After release, a new request completes normally.
- **Back-to-back writes:** `req0` is re-asserted in the cycle after each `gnt`.
  - Expect exactly one `mem_write` pulse every 2 cycles, and never `mem_read` and `mem_write` high together.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} arb_state_t;

   localparam int unsigned REQ_CORE   = 0;
   localparam int unsigned REQ_STACK  = 1;
   localparam int unsigned RD_LAT_MAX = 4;
   localparam int unsigned CNT_W      = $clog2(RD_LAT_MAX);

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection; DMEM_ARB_RR_EN switches ties from fixed priority to round-robin.
module dmem_arb_pick
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req_i,
`ifdef DMEM_ARB_RR_EN
   input  logic       last_i,
`endif
   output logic       winner_o,
   output logic       valid_o
);

   always_comb begin
      valid_o  = |req_i;
      winner_o = req_i[REQ_CORE] ? 1'b0 : 1'b1;
`ifdef DMEM_ARB_RR_EN
      // On a tie the requester that was not served last goes next.
      if (req_i[REQ_CORE] && req_i[REQ_STACK]) winner_o = ~last_i;
`endif
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-outstanding arbiter for the data memory (core load/store vs. stack push/pop).
// Build with DMEM_ARB_RR_EN defined for round-robin ties; otherwise requester 0 has priority.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        req,
   input  logic [1:0]        we,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic [1:0]        gnt,
   output logic [1:0]        rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_lat_chk
      $error("dmem_arbiter: RD_LAT must be within 1..RD_LAT_MAX");
   end

   localparam logic [CNT_W-1:0] CntLoad = CNT_W'(RD_LAT - 1);

   arb_state_t        state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              idx_q;
   logic              cmd_we_q;
   logic [1:0]        gnt_q;
   logic [1:0]        rvalid_q;
   logic              mem_read_q;
   logic              mem_write_q;
   logic              busy_q;
   logic [DATA_W-1:0] rdata_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic              pick_winner;
   logic              pick_valid;
`ifdef DMEM_ARB_RR_EN
   logic              last_q;
`endif

   dmem_arb_pick u_pick (
      .req_i    (req),
`ifdef DMEM_ARB_RR_EN
      .last_i   (last_q),
`endif
      .winner_o (pick_winner),
      .valid_o  (pick_valid)
   );

   // mem_addr_q/mem_wdata_q double as the command address/data registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= 1'b0;
         cmd_we_q    <= 1'b0;
         gnt_q       <= '0;
         rvalid_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         busy_q      <= 1'b0;
         rdata_q     <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
`ifdef DMEM_ARB_RR_EN
         last_q      <= 1'b1;
`endif
      end else begin
         gnt_q       <= '0;
         rvalid_q    <= '0;
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (pick_valid) begin
                  idx_q       <= pick_winner;
                  cmd_we_q    <= we[pick_winner];
                  mem_addr_q  <= pick_winner ? addr1 : addr0;
                  mem_wdata_q <= pick_winner ? wdata1 : wdata0;
                  gnt_q       <= pick_winner ? 2'b10 : 2'b01;
                  mem_write_q <= we[pick_winner];
                  mem_read_q  <= ~we[pick_winner];
                  busy_q      <= 1'b1;
                  state_q     <= ISSUE;
`ifdef DMEM_ARB_RR_EN
                  last_q      <= pick_winner;
`endif
               end
            end
            ISSUE: begin
               if (cmd_we_q) begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= CntLoad;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == '0) begin
                  rdata_q  <= mem_rdata;
                  rvalid_q <= idx_q ? 2'b10 : 2'b01;
                  state_q  <= RESP;
               end else begin
                  cnt_q <= cnt_q - CNT_W'(1);
               end
            end
            RESP: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign rvalid    = rvalid_q;
   assign rdata     = rdata_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: requester agents push expected transactions, a monitor
// checks grants, strobes, read responses and timing against a transaction-level model.
module tb_dmem_arbiter;

   localparam int unsigned RD_LAT = 2;
`ifdef DMEM_ARB_RR_EN
   localparam bit RR_EN = 1'b1;
`else
   localparam bit RR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  req = '0, we = '0;
   logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
   logic [1:0]  gnt, rvalid;
   logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(RD_LAT)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .we        (we),
      .addr0     (addr0),
      .addr1     (addr1),
      .wdata0    (wdata0),
      .wdata1    (wdata1),
      .gnt       (gnt),
      .rvalid    (rvalid),
      .rdata     (rdata),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .busy      (busy)
   );

   typedef struct packed {logic w; logic [31:0] a; logic [31:0] d;} txn_t;
   typedef struct packed {logic r; logic [31:0] d; int unsigned due;} rd_t;

   txn_t        sbq0[$], sbq1[$];
   rd_t         rdq[$];
   logic [1:0]  glog[$];
   logic [31:0] mem_m [logic [31:0]];
   int          total = 0, bad = 0;

   function automatic logic [31:0] mem_get(input logic [31:0] a);
      if (mem_m.exists(a)) return mem_m[a];
      return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Memory: read data is valid only in the cycle the arbiter must sample it.
   int unsigned cnt_m = 0;
   logic [31:0] raddr_m = '0;
   logic        good_m;
   always @(posedge clk) begin
      #1;
      good_m = 1'b0;
      if (!rst) cnt_m = 0;
      else if (mem_read) begin
         cnt_m = RD_LAT;
         raddr_m = mem_addr;
      end else if (cnt_m > 0) begin
         cnt_m--;
         good_m = (cnt_m == 0);
      end
      mem_rdata = good_m ? mem_get(raddr_m) : $urandom;
   end

   // Transaction-level model of the arbiter, evaluated once per cycle.
   int unsigned cyc = 0, idle_due = 0, last_wr = 0;
   logic        inflight = 1'b0, idle_prev = 1'b1, last_m = 1'b1, b2b = 1'b0;
   logic        m_exp_now, m_w, m_have;
   logic [31:0] rdata_m = '0;
   txn_t        m_t;
   rd_t         m_r;
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst) begin
         inflight = 1'b0; idle_prev = 1'b1; idle_due = 0; last_m = 1'b1;
         rdata_m = '0; last_wr = 0;
         rdq.delete(); sbq0.delete(); sbq1.delete();
      end else begin
         m_exp_now = idle_prev && (req != 2'b00);
         chk("gnt_timing", 64'(gnt != 2'b00), 64'(m_exp_now));
         if (m_exp_now) begin
            m_w = (req == 2'b11) ? (RR_EN ? ~last_m : 1'b0) : req[1];
            chk("gnt_winner", 64'(gnt), m_w ? 64'h2 : 64'h1);
            glog.push_back(gnt);
            last_m = m_w;
            inflight = 1'b1;
            m_have = m_w ? (sbq1.size() != 0) : (sbq0.size() != 0);
            chk("gnt_has_txn", 64'(m_have), 64'h1);
            if (m_have) begin
               m_t = m_w ? sbq1.pop_front() : sbq0.pop_front();
               chk("mem_write", 64'(mem_write), 64'(m_t.w));
               chk("mem_read", 64'(mem_read), 64'(!m_t.w));
               chk("mem_addr", 64'(mem_addr), 64'(m_t.a));
               chk("busy_issue", 64'(busy), 64'h1);
               if (m_t.w) begin
                  chk("mem_wdata", 64'(mem_wdata), 64'(m_t.d));
                  mem_m[m_t.a] = m_t.d;
                  idle_due = cyc + 1;
                  if (b2b && last_wr != 0) chk("b2b_gap", 64'(cyc - last_wr), 64'h2);
                  last_wr = cyc;
               end else begin
                  rdq.push_back('{r: m_w, d: mem_get(m_t.a), due: cyc + 1 + RD_LAT});
               end
            end
         end else begin
            chk("strobe_idle", 64'({mem_read, mem_write}), 64'h0);
         end
         chk("strobe_excl", 64'(mem_read && mem_write), 64'h0);
         if (rdq.size() != 0 && rdq[0].due == cyc) begin
            m_r = rdq.pop_front();
            chk("rvalid", 64'(rvalid), m_r.r ? 64'h2 : 64'h1);
            chk("rdata", 64'(rdata), 64'(m_r.d));
            rdata_m = m_r.d;
            idle_due = cyc + 1;
         end else begin
            chk("rvalid_quiet", 64'(rvalid), 64'h0);
            chk("rdata_hold", 64'(rdata), 64'(rdata_m));
         end
         if (idle_due == cyc) begin
            chk("busy_idle", 64'(busy), 64'h0);
            inflight = 1'b0;
         end
         if (!b2b) last_wr = 0;
         idle_prev = !inflight;
      end
   end

   task automatic start(input int r, input logic w, input logic [31:0] a, input logic [31:0] d);
      if (r == 0) begin addr0 = a; wdata0 = d; end
      else begin addr1 = a; wdata1 = d; end
      we[r]  = w;
      req[r] = 1'b1;
      if (r == 0) sbq0.push_back('{w: w, a: a, d: d});
      else sbq1.push_back('{w: w, a: a, d: d});
   endtask

   // One cycle of requester behaviour: drop after grant, maybe issue a new request.
   task automatic step(input int p_new, input logic wr_only, input logic [1:0] mask);
      @(negedge clk);
      for (int r = 0; r < 2; r++) begin
         if (req[r] && gnt[r]) req[r] = 1'b0;
         if (!req[r] && mask[r] && $urandom_range(99) < p_new)
            start(r, wr_only ? 1'b1 : 1'($urandom_range(1)),
                  {26'd0, 4'($urandom_range(15)), 2'b00}, $urandom);
      end
   endtask

   task automatic wait_idle();
      int k = 0;
      while ((req != 2'b00 || sbq0.size() != 0 || sbq1.size() != 0 || rdq.size() != 0 ||
              inflight) && k < 60) begin
         step(0, 1'b0, 2'b00);
         k++;
      end
      chk("drain_timeout", 64'(k >= 60), 64'h0);
   endtask

   logic [1:0] tie_exp [3];
   int         k;

   initial begin
      repeat (3) @(negedge clk);
      chk("reset_ctrl", 64'({gnt, rvalid, mem_read, mem_write, busy}), 64'h0);
      chk("reset_rdata", 64'(rdata), 64'h0);
      chk("reset_mem_bus", {mem_addr, mem_wdata}, 64'h0);
      rst = 1'b1;
      @(negedge clk);

      start(0, 1'b1, 32'h10, 32'hDEADBEEF);
      wait_idle();
      mem_m[32'h7C] = 32'h12345678;
      start(1, 1'b0, 32'h7C, 32'h0);
      wait_idle();
      chk("read_7c_rdata", 64'(rdata), 64'h12345678);

      // Tie with both requesters writing continuously.
      glog.delete();
      start(0, 1'b1, 32'h40, $urandom);
      start(1, 1'b1, 32'h44, $urandom);
      k = 0;
      while (glog.size() < 3 && k < 20) begin step(100, 1'b1, 2'b11); k++; end
      wait_idle();
      tie_exp[0] = 2'b01;
      tie_exp[1] = RR_EN ? 2'b10 : 2'b01;
      tie_exp[2] = 2'b01;
      chk("tie_count", 64'(glog.size() >= 3), 64'h1);
      for (int i = 0; i < 3; i++)
         if (i < glog.size()) chk($sformatf("tie_order%0d", i), 64'(glog[i]), 64'(tie_exp[i]));

      b2b = 1'b1;
      start(0, 1'b1, 32'h80, $urandom);
      repeat (12) step(100, 1'b1, 2'b01);
      b2b = 1'b0;
      wait_idle();

      // Reset while a read is in WAIT.
      start(0, 1'b0, 32'h7C, 32'h0);
      k = 0;
      while (rdq.size() == 0 && k < 20) begin step(0, 1'b0, 2'b00); k++; end
      chk("mid_read_grant", 64'(k < 20), 64'h1);
      step(0, 1'b0, 2'b00);
      rst = 1'b0;
      req = 2'b00;
      #1;
      chk("midrst_ctrl", 64'({gnt, rvalid, mem_read, mem_write, busy}), 64'h0);
      chk("midrst_rdata", 64'(rdata), 64'h0);
      chk("midrst_mem_bus", {mem_addr, mem_wdata}, 64'h0);
      repeat (2) step(0, 1'b0, 2'b00);
      rst = 1'b1;
      repeat (6) step(0, 1'b0, 2'b00);
      start(1, 1'b0, 32'h7C, 32'h0);
      wait_idle();
      chk("post_reset_read", 64'(rdata), 64'h12345678);

      repeat (400) step(40, 1'b0, 2'b11);
      wait_idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
